// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, FSM encodings and the prediction-queue entry for the branch resolve unit.
package branch_resolve_unit_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [0:0] BRU_RUN     = 1'b0;
    localparam logic [0:0] BRU_RECOVER = 1'b1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_entry_t;

    // Fall-through PC; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-flight prediction queue: sync FIFO with clear (priority over push) and combinational head.
module branch_resolve_unit_pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t din,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pred_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares fetch-time predictions with execute-time outcomes, trains the bpu and
// redirects/flushes the front end on a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pred_valid,
    input  logic [PC_W-1:0]  i_pred_pc,
    input  logic             i_pred_taken,
    input  logic [PC_W-1:0]  i_pred_target,
    output logic             o_pred_ready,
    input  logic             i_res_valid,
    input  logic [PC_W-1:0]  i_res_pc,
    input  logic             i_res_taken,
    input  logic [PC_W-1:0]  i_res_target,
    output logic             o_upd_valid,
    output logic [PC_W-1:0]  o_upd_pc,
    output logic [PC_W-1:0]  o_upd_target,
    output logic             o_upd_taken,
    output logic             o_redirect,
    output logic [PC_W-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int unsigned RC_W = $clog2(RECOVER_CYCLES + 1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [RC_W-1:0]  rcnt;
    logic [RC_W-1:0]  rcnt_nxt;

    pred_entry_t      push_entry;
    pred_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_c;
    logic             pop_c;
    logic             res_fire_c;
    logic             mispredict_c;

    logic             upd_valid_nxt;
    logic [PC_W-1:0]  upd_pc_nxt;
    logic [PC_W-1:0]  upd_target_nxt;
    logic             upd_taken_nxt;
    logic             redirect_nxt;
    logic [PC_W-1:0]  redirect_pc_nxt;
    logic             flush_nxt;
    logic [CNT_W-1:0] branch_cnt_nxt;
    logic [CNT_W-1:0] mispredict_cnt_nxt;

    // Ready depends only on flops: no same-cycle pop bypass.
    assign o_pred_ready = !fifo_full && (state == BRU_RUN);

    assign push_entry = '{pc: i_pred_pc, taken: i_pred_taken, target: i_pred_target};
    assign res_fire_c = i_res_valid && (state == BRU_RUN);
    assign mispredict_c = res_fire_c &&
                          (fifo_empty ||
                           (head.pc != i_res_pc) ||
                           (head.taken != i_res_taken) ||
                           (head.taken && i_res_taken && (head.target != i_res_target)));
    assign pop_c  = res_fire_c && !fifo_empty;
    assign push_c = i_pred_valid && o_pred_ready;

    branch_resolve_unit_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .clear (mispredict_c),
        .din   (push_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= BRU_RUN;
            rcnt             <= '0;
            o_upd_valid      <= 1'b0;
            o_upd_pc         <= '0;
            o_upd_target     <= '0;
            o_upd_taken      <= 1'b0;
            o_redirect       <= 1'b0;
            o_redirect_pc    <= '0;
            o_flush          <= 1'b0;
            o_branch_cnt     <= '0;
            o_mispredict_cnt <= '0;
        end else begin
            state            <= state_nxt;
            rcnt             <= rcnt_nxt;
            o_upd_valid      <= upd_valid_nxt;
            o_upd_pc         <= upd_pc_nxt;
            o_upd_target     <= upd_target_nxt;
            o_upd_taken      <= upd_taken_nxt;
            o_redirect       <= redirect_nxt;
            o_redirect_pc    <= redirect_pc_nxt;
            o_flush          <= flush_nxt;
            o_branch_cnt     <= branch_cnt_nxt;
            o_mispredict_cnt <= mispredict_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        rcnt_nxt           = rcnt;
        upd_valid_nxt      = 1'b0;
        upd_pc_nxt         = o_upd_pc;
        upd_target_nxt     = o_upd_target;
        upd_taken_nxt      = o_upd_taken;
        redirect_nxt       = 1'b0;
        redirect_pc_nxt    = o_redirect_pc;
        branch_cnt_nxt     = o_branch_cnt;
        mispredict_cnt_nxt = o_mispredict_cnt;

        case (state)
            BRU_RUN: begin
                if (mispredict_c) begin
                    state_nxt = BRU_RECOVER;
                    rcnt_nxt  = '0;
                end
            end
            BRU_RECOVER: begin
                if (rcnt == RC_W'(RECOVER_CYCLES - 1)) begin
                    state_nxt = BRU_RUN;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + RC_W'(1);
                end
            end
            default: begin
                state_nxt = BRU_RUN;
                rcnt_nxt  = '0;
            end
        endcase

        if (res_fire_c) begin
            upd_valid_nxt  = 1'b1;
            upd_pc_nxt     = i_res_pc;
            upd_target_nxt = i_res_target;
            upd_taken_nxt  = i_res_taken;
            if (o_branch_cnt != '1) branch_cnt_nxt = o_branch_cnt + CNT_W'(1);
        end

        if (mispredict_c) begin
            redirect_nxt    = 1'b1;
            redirect_pc_nxt = i_res_taken ? i_res_target : next_seq_pc(i_res_pc);
            if (o_mispredict_cnt != '1) mispredict_cnt_nxt = o_mispredict_cnt + CNT_W'(1);
        end

        flush_nxt = (state_nxt == BRU_RECOVER);
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized checks of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int RC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pred_valid;
    logic [31:0]   i_pred_pc;
    logic          i_pred_taken;
    logic [31:0]   i_pred_target;
    logic          o_pred_ready;
    logic          i_res_valid;
    logic [31:0]   i_res_pc;
    logic          i_res_taken;
    logic [31:0]   i_res_target;
    logic          o_upd_valid;
    logic [31:0]   o_upd_pc;
    logic [31:0]   o_upd_target;
    logic          o_upd_taken;
    logic          o_redirect;
    logic [31:0]   o_redirect_pc;
    logic          o_flush;
    logic [CW-1:0] o_branch_cnt;
    logic [CW-1:0] o_mispredict_cnt;

    branch_resolve_unit #(
        .DEPTH          (DEPTH),
        .RECOVER_CYCLES (RC),
        .CNT_W          (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_pred_valid     (i_pred_valid),
        .i_pred_pc        (i_pred_pc),
        .i_pred_taken     (i_pred_taken),
        .i_pred_target    (i_pred_target),
        .o_pred_ready     (o_pred_ready),
        .i_res_valid      (i_res_valid),
        .i_res_pc         (i_res_pc),
        .i_res_taken      (i_res_taken),
        .i_res_target     (i_res_target),
        .o_upd_valid      (o_upd_valid),
        .o_upd_pc         (o_upd_pc),
        .o_upd_target     (o_upd_target),
        .o_upd_taken      (o_upd_taken),
        .o_redirect       (o_redirect),
        .o_redirect_pc    (o_redirect_pc),
        .o_flush          (o_flush),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispredict_cnt (o_mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    int          m_rec;
    int          m_bcnt;
    int          m_mcnt;
    logic        m_upd_valid;
    logic [31:0] m_upd_pc;
    logic [31:0] m_upd_tgt;
    logic        m_upd_taken;
    logic        m_redirect;
    logic [31:0] m_redir_pc;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                        input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                        input logic rstn);
        bit   rdy;
        bit   mis;
        ent_t e;
        i_pred_valid  = pv;
        i_pred_pc     = ppc;
        i_pred_taken  = pt;
        i_pred_target = ptgt;
        i_res_valid   = rv;
        i_res_pc      = rpc;
        i_res_taken   = rt;
        i_res_target  = rtgt;
        rst_n         = rstn;
        rdy = (mq.size() < DEPTH) && (m_rec == 0);
        mis = 1'b0;
        @(posedge clk);
        #1;
        m_upd_valid = 1'b0;
        m_redirect  = 1'b0;
        if (!rstn) begin
            mq.delete();
            m_rec = 0; m_bcnt = 0; m_mcnt = 0;
            m_upd_pc = '0; m_upd_tgt = '0; m_upd_taken = 1'b0; m_redir_pc = '0;
        end else if (m_rec > 0) begin
            m_rec--;
        end else begin
            if (rv) begin
                if (m_bcnt < CMAX) m_bcnt++;
                m_upd_valid = 1'b1;
                m_upd_pc    = rpc;
                m_upd_tgt   = rtgt;
                m_upd_taken = rt;
                if (mq.size() == 0) mis = 1'b1;
                else begin
                    e = mq[0];
                    if (e.pc != rpc || e.taken != rt || (e.taken && rt && e.target != rtgt)) mis = 1'b1;
                end
                if (mis) begin
                    mq.delete();
                    m_rec = RC;
                    if (m_mcnt < CMAX) m_mcnt++;
                    m_redirect = 1'b1;
                    m_redir_pc = rt ? rtgt : rpc + 32'd4;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (pv && rdy && !mis) mq.push_back('{pc: ppc, taken: pt, target: ptgt});
        end
        chk("ready",     32'(o_pred_ready), 32'((mq.size() < DEPTH) && (m_rec == 0)));
        chk("upd_valid", 32'(o_upd_valid),  32'(m_upd_valid));
        chk("redirect",  32'(o_redirect),   32'(m_redirect));
        chk("flush",     32'(o_flush),      32'(m_rec > 0));
        chk("branch_cnt",     32'(o_branch_cnt),     32'(m_bcnt));
        chk("mispredict_cnt", 32'(o_mispredict_cnt), 32'(m_mcnt));
        if (m_upd_valid) begin
            chk("upd_pc",     o_upd_pc,            m_upd_pc);
            chk("upd_target", o_upd_target,        m_upd_tgt);
            chk("upd_taken",  32'(o_upd_taken),    32'(m_upd_taken));
        end
        if (m_redirect) chk("redirect_pc", o_redirect_pc, m_redir_pc);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(1'b1, pc, t, tgt, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(1'b0, '0, 1'b0, '0, 1'b1, pc, t, tgt, 1'b1);
    endtask

    initial begin
        logic        pv, pt, rv, rt, rs;
        logic [31:0] ppc, ptgt, rpc, rtgt;
        m_rec = 0; m_bcnt = 0; m_mcnt = 0;
        m_upd_valid = 1'b0; m_redirect = 1'b0;
        m_upd_pc = '0; m_upd_tgt = '0; m_upd_taken = 1'b0; m_redir_pc = '0;

        // Reset held two cycles
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("t1_ready", 32'(o_pred_ready), 32'd1);
        chk("t1_flush", 32'(o_flush), 32'd0);
        chk("t1_bcnt",  32'(o_branch_cnt), 32'd0);

        // Correctly predicted not-taken branch
        push(32'h10, 1'b0, 32'h14);
        resolve(32'h10, 1'b0, 32'h0);
        chk("t2_upd_valid", 32'(o_upd_valid), 32'd1);
        chk("t2_upd_pc",    o_upd_pc, 32'h10);
        chk("t2_upd_taken", 32'(o_upd_taken), 32'd0);
        chk("t2_redirect",  32'(o_redirect), 32'd0);
        chk("t2_bcnt",      32'(o_branch_cnt), 32'd1);
        chk("t2_mcnt",      32'(o_mispredict_cnt), 32'd0);

        // Direction mispredict
        push(32'h14, 1'b0, 32'h18);
        resolve(32'h14, 1'b1, 32'h28);
        chk("t3_redirect",    32'(o_redirect), 32'd1);
        chk("t3_redirect_pc", o_redirect_pc, 32'h28);
        chk("t3_flush0",      32'(o_flush), 32'd1);
        chk("t3_ready0",      32'(o_pred_ready), 32'd0);
        chk("t3_mcnt",        32'(o_mispredict_cnt), 32'd1);
        idle();
        chk("t3_flush1",      32'(o_flush), 32'd1);
        chk("t3_redirect1",   32'(o_redirect), 32'd0);
        idle();
        chk("t3_flush2",      32'(o_flush), 32'd0);
        chk("t3_ready2",      32'(o_pred_ready), 32'd1);

        // Target mispredict, then not-taken wrap at top of address space
        push(32'h18, 1'b1, 32'h30);
        resolve(32'h18, 1'b1, 32'h40);
        chk("t4_redirect_pc", o_redirect_pc, 32'h40);
        idle(); idle();
        push(32'hFFFF_FFFC, 1'b1, 32'h100);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("t4_wrap_redirect", 32'(o_redirect), 32'd1);
        chk("t4_wrap_pc",       o_redirect_pc, 32'h0);
        idle(); idle();

        // Fill the queue; 5th push is dropped
        push(32'h100, 1'b1, 32'h200);
        push(32'h104, 1'b0, 32'h108);
        push(32'h108, 1'b1, 32'h300);
        push(32'h10C, 1'b0, 32'h110);
        chk("t5_full_ready", 32'(o_pred_ready), 32'd0);
        push(32'h110, 1'b1, 32'h400);
        resolve(32'h100, 1'b1, 32'h200);
        step(1'b1, 32'h114, 1'b1, 32'h500, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1);
        chk("t5_pushpop_ready", 32'(o_pred_ready), 32'd1);
        resolve(32'h108, 1'b1, 32'h300);
        resolve(32'h10C, 1'b0, 32'h0);
        resolve(32'h114, 1'b1, 32'h500);
        chk("t5_order_redirect", 32'(o_redirect), 32'd0);
        chk("t5_mcnt",           32'(o_mispredict_cnt), 32'd3);

        // Mispredict with concurrent push, then resolve against the emptied queue
        push(32'h200, 1'b1, 32'h300);
        step(1'b1, 32'h204, 1'b0, 32'h208, 1'b1, 32'h200, 1'b1, 32'h304, 1'b1);
        chk("t6_redirect_pc", o_redirect_pc, 32'h304);
        idle(); idle();
        resolve(32'h204, 1'b0, 32'h0);
        chk("t6_empty_redirect", 32'(o_redirect), 32'd1);
        chk("t6_empty_pc",       o_redirect_pc, 32'h208);
        step(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        chk("t6_rst_ready",    32'(o_pred_ready), 32'd1);
        chk("t6_rst_flush",    32'(o_flush), 32'd0);
        chk("t6_rst_redirect", 32'(o_redirect), 32'd0);
        chk("t6_rst_upd",      32'(o_upd_valid), 32'd0);
        chk("t6_rst_mcnt",     32'(o_mispredict_cnt), 32'd0);

        // Randomized traffic, mostly-correct resolutions drawn from the model queue
        for (int n = 0; n < 800; n++) begin
            pv   = 1'($urandom_range(0, 1));
            ppc  = {24'h0, 8'($urandom_range(0, 255))} & ~32'h3;
            pt   = 1'($urandom_range(0, 1));
            ptgt = $urandom & ~32'h3;
            if ($urandom_range(0, 7) == 0) ptgt = ptgt | 32'hFFFF_FF00;
            rv   = ($urandom_range(0, 2) == 0);
            rpc  = {24'h0, 8'($urandom_range(0, 255))} & ~32'h3;
            rt   = 1'($urandom_range(0, 1));
            rtgt = $urandom & ~32'h3;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            if (rv && mq.size() > 0 && $urandom_range(0, 9) < 8) begin
                rpc  = mq[0].pc;
                rt   = mq[0].taken;
                rtgt = mq[0].taken ? mq[0].target : $urandom;
            end
            rs = ($urandom_range(0, 99) != 0);
            step(pv, ppc, pt, ptgt, rv, rpc, rt, rtgt, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
